// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcode, class and funct3 constants shared by encode and decode sides
package riscv_pkg;

    localparam logic [6:0] OPC_ALU_I = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    typedef enum logic [1:0] {
        CLS_ALU_I = 2'd0,
        CLS_LW    = 2'd1,
        CLS_SW    = 2'd2,
        CLS_BEQ   = 2'd3
    } instr_class_e;

    // Branch offsets must be halfword aligned; everything else must fit 12-bit signed.
    function automatic logic imm_legal(input instr_class_e cls, input logic [12:0] imm);
        if (cls == CLS_BEQ) begin
            imm_legal = ~imm[0];
        end else begin
            imm_legal = (imm[12] == imm[11]);
        end
    endfunction

endpackage

// File: rtl/instr_field_pack.sv
// rtl/instr_field_pack.sv - combinational packing of one descriptor into an RV32I word
module instr_field_pack
    import riscv_pkg::*;
(
    input  instr_class_e i_class,
    input  logic [4:0]   i_rd,
    input  logic [4:0]   i_rs1,
    input  logic [4:0]   i_rs2,
    input  logic [2:0]   i_funct3,
    input  logic [12:0]  i_imm,
    output logic [31:0]  o_word,
    output logic         o_legal
);

    always_comb begin
        o_word  = 32'd0;
        o_legal = imm_legal(i_class, i_imm);
        case (i_class)
            CLS_ALU_I: o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, OPC_ALU_I};
            CLS_LW:    o_word = {i_imm[11:0], i_rs1, F3_WORD, i_rd, OPC_LOAD};
            CLS_SW:    o_word = {i_imm[11:5], i_rs2, i_rs1, F3_WORD, i_imm[4:0], OPC_STORE};
            CLS_BEQ:   o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, F3_BEQ,
                                 i_imm[4:1], i_imm[11], OPC_BRANCH};
            default:   o_word = 32'd0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - streaming RV32I assembler writing encoded words into instruction memory
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              finish_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [1:0]        in_class_i,
    input  logic [4:0]        in_rd_i,
    input  logic [4:0]        in_rs1_i,
    input  logic [4:0]        in_rs2_i,
    input  logic [2:0]        in_funct3_i,
    input  logic [12:0]       in_imm_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic [ADDR_W:0]   count_o,
    output logic              err_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LP_LAST  = (ADDR_W+1)'(DEPTH - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W:0]   r_alloc;
    logic [ADDR_W:0]   r_count;
    logic              r_err;

    logic              r_s1_valid;
    instr_class_e      r_s1_class;
    logic [4:0]        r_s1_rd;
    logic [4:0]        r_s1_rs1;
    logic [4:0]        r_s1_rs2;
    logic [2:0]        r_s1_funct3;
    logic [12:0]       r_s1_imm;
    logic [ADDR_W-1:0] r_s1_addr;

    logic              r_s2_valid;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [31:0]       r_wr_data;

    instr_class_e      w_in_class;
    logic              w_start;
    logic              w_accept;
    logic              w_in_legal;
    logic              w_acc_legal;
    logic [31:0]       w_word;
    logic              w_pack_legal;
    logic              w_s2_load;

    assign w_in_class  = instr_class_e'(in_class_i);
    assign in_ready_o  = (r_state == ST_RUN) && (r_alloc < LP_DEPTH);
    assign w_start     = start_i && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_accept    = in_valid_i && in_ready_o;
    assign w_in_legal  = imm_legal(w_in_class, in_imm_i);
    assign w_acc_legal = w_accept && w_in_legal;
    assign w_s2_load   = r_s1_valid && w_pack_legal;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (start_i) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (finish_i || (w_acc_legal && (r_alloc == LP_LAST))) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            // S2 empties on the same edge that S1 is found empty, so DONE follows the last write.
            ST_DRAIN: if (!r_s1_valid) w_state_nxt = ST_DONE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_alloc <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (w_start) begin
            r_alloc <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_acc_legal) r_alloc <= r_alloc + 1'b1;
            if (w_s2_load)   r_count <= r_count + 1'b1;
            if (w_accept && !w_in_legal) r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1_valid  <= 1'b0;
            r_s1_class  <= CLS_ALU_I;
            r_s1_rd     <= '0;
            r_s1_rs1    <= '0;
            r_s1_rs2    <= '0;
            r_s1_funct3 <= '0;
            r_s1_imm    <= '0;
            r_s1_addr   <= '0;
        end else begin
            r_s1_valid <= w_acc_legal;
            if (w_acc_legal) begin
                r_s1_class  <= w_in_class;
                r_s1_rd     <= in_rd_i;
                r_s1_rs1    <= in_rs1_i;
                r_s1_rs2    <= in_rs2_i;
                r_s1_funct3 <= in_funct3_i;
                r_s1_imm    <= in_imm_i;
                r_s1_addr   <= r_alloc[ADDR_W-1:0];
            end
        end
    end

    instr_field_pack u_pack (
        .i_class  (r_s1_class),
        .i_rd     (r_s1_rd),
        .i_rs1    (r_s1_rs1),
        .i_rs2    (r_s1_rs2),
        .i_funct3 (r_s1_funct3),
        .i_imm    (r_s1_imm),
        .o_word   (w_word),
        .o_legal  (w_pack_legal)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s2_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_s2_valid <= w_s2_load;
            if (w_s2_load) begin
                r_wr_addr <= r_s1_addr;
                r_wr_data <= w_word;
            end
        end
    end

    assign wr_en_o   = r_s2_valid;
    assign wr_addr_o = r_wr_addr;
    assign wr_data_o = r_wr_data;
    assign count_o   = r_count;
    assign err_o     = r_err;
    assign busy_o    = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done_o    = (r_state == ST_DONE);

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder (DEPTH 256 and DEPTH 4 instances)
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, finish0, start4, finish4;
    logic        in_valid;
    logic [1:0]  in_class;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_f3;
    logic [12:0] in_imm;

    logic        rdy0, wen0, err0, busy0, done0;
    logic [7:0]  waddr0;
    logic [31:0] wdata0;
    logic [8:0]  cnt0;
    logic        rdy4, wen4, err4, busy4, done4;
    logic [1:0]  waddr4;
    logic [31:0] wdata4;
    logic [2:0]  cnt4;

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q4[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   exp_addr = 0;

    instr_encoder #(.DEPTH(256)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start0), .finish_i(finish0),
        .in_valid_i(in_valid), .in_ready_o(rdy0), .in_class_i(in_class),
        .in_rd_i(in_rd), .in_rs1_i(in_rs1), .in_rs2_i(in_rs2),
        .in_funct3_i(in_f3), .in_imm_i(in_imm),
        .wr_en_o(wen0), .wr_addr_o(waddr0), .wr_data_o(wdata0),
        .count_o(cnt0), .err_o(err0), .busy_o(busy0), .done_o(done0)
    );

    instr_encoder #(.DEPTH(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start4), .finish_i(finish4),
        .in_valid_i(in_valid), .in_ready_o(rdy4), .in_class_i(in_class),
        .in_rd_i(in_rd), .in_rs1_i(in_rs1), .in_rs2_i(in_rs2),
        .in_funct3_i(in_f3), .in_imm_i(in_imm),
        .wr_en_o(wen4), .wr_addr_o(waddr4), .wr_data_o(wdata4),
        .count_o(cnt4), .err_o(err4), .busy_o(busy4), .done_o(done4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (wen0 === 1'b1) begin
            if (q0.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL dut0_unexpected_write: addr %h data %h", waddr0, wdata0);
            end else begin
                e = q0.pop_front();
                chk("dut0_wr_addr", 32'(waddr0), e.addr);
                chk("dut0_wr_data", wdata0, e.data);
                chk("dut0_wr_cycle", cyc, e.cyc);
            end
        end
        if (wen4 === 1'b1) begin
            if (q4.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL dut4_unexpected_write: addr %h data %h", waddr4, wdata4);
            end else begin
                e = q4.pop_front();
                chk("dut4_wr_addr", 32'(waddr4), e.addr);
                chk("dut4_wr_data", wdata4, e.data);
                chk("dut4_wr_cycle", cyc, e.cyc);
            end
        end
    end

    // Called at a negedge; returns at the negedge after acceptance with in_valid still high.
    task automatic send(input bit sel4, input logic [1:0] cls, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [12:0] imm, input bit push, input logic [31:0] data);
        int   waits = 0;
        exp_t e;
        in_class = cls; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_f3 = f3; in_imm = imm;
        in_valid = 1'b1;
        while (!(sel4 ? rdy4 : rdy0) && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 20) begin
            n_chk++;
            n_fail++;
            $display("FAIL handshake_timeout: ready 0 expected 1");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (push) begin
            e.addr = exp_addr;
            e.data = data;
            e.cyc  = cyc + 1;
            if (sel4) q4.push_back(e);
            else      q0.push_back(e);
            exp_addr++;
        end
        @(negedge clk);
    endtask

    task automatic pulse_start(input bit sel4);
        if (sel4) start4 = 1'b1; else start0 = 1'b1;
        exp_addr = 0;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start4 = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_finish();
        finish0 = 1'b1;
        @(posedge clk);
        #1;
        finish0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input bit sel4);
        int n = 0;
        while (!(sel4 ? done4 : done0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(sel4 ? "dut4_done" : "dut0_done", 32'(sel4 ? done4 : done0), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        start0 = 1'b0; finish0 = 1'b0; start4 = 1'b0; finish4 = 1'b0;
        in_valid = 1'b0; in_class = 2'd0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_f3 = '0; in_imm = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("reset_in_ready", 32'(rdy0), 32'd0);
        chk("reset_wr_en", 32'(wen0), 32'd0);
        chk("reset_wr_addr", 32'(waddr0), 32'd0);
        chk("reset_wr_data", wdata0, 32'd0);
        chk("reset_count", 32'(cnt0), 32'd0);
        chk("reset_err", 32'(err0), 32'd0);
        chk("reset_busy", 32'(busy0), 32'd0);
        chk("reset_done", 32'(done0), 32'd0);

        // Single ALU_I addi x1, x0, 5
        pulse_start(1'b0);
        chk("run_busy", 32'(busy0), 32'd1);
        send(1'b0, 2'd0, 5'd1, 5'd0, 5'd0, 3'd0, 13'd5, 1'b1, 32'h00500093);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        pulse_finish();
        wait_done(1'b0);
        chk("t1_count", 32'(cnt0), 32'd1);

        // Back-to-back LW (funct3 input ignored), SW (rd ignored), BEQ with coincident finish
        pulse_start(1'b0);
        send(1'b0, 2'd1, 5'd2, 5'd1, 5'd0, 3'd7, 13'd8, 1'b1, 32'h0080A103);
        send(1'b0, 2'd2, 5'd31, 5'd1, 5'd2, 3'd0, 13'd12, 1'b1, 32'h0020A623);
        finish0 = 1'b1;
        send(1'b0, 2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 13'h1FFC, 1'b1, 32'hFE208EE3);
        finish0 = 1'b0;
        in_valid = 1'b0;
        chk("t2_busy_drain", 32'(busy0), 32'd1);
        wait_done(1'b0);
        chk("t2_count", 32'(cnt0), 32'd3);
        chk("t2_err", 32'(err0), 32'd0);

        // Illegal BEQ imm=3 and ALU_I imm=2048 are consumed without allocating an address
        pulse_start(1'b0);
        send(1'b0, 2'd0, 5'd1, 5'd1, 5'd0, 3'd0, 13'd1, 1'b1, 32'h00108093);
        send(1'b0, 2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 13'd3, 1'b0, 32'd0);
        send(1'b0, 2'd0, 5'd1, 5'd1, 5'd0, 3'd0, 13'd2048, 1'b0, 32'd0);
        send(1'b0, 2'd0, 5'd3, 5'd4, 5'd0, 3'd7, 13'h1FFF, 1'b1, 32'hFFF27193);
        in_valid = 1'b0;
        chk("t3_err", 32'(err0), 32'd1);
        repeat (3) @(negedge clk);
        pulse_finish();
        wait_done(1'b0);
        chk("t3_count", 32'(cnt0), 32'd2);
        chk("t3_err_sticky", 32'(err0), 32'd1);

        // Restart clears err/count; SW -2048 with finish in the same cycle
        pulse_start(1'b0);
        chk("t4_err_cleared", 32'(err0), 32'd0);
        chk("t4_count_cleared", 32'(cnt0), 32'd0);
        finish0 = 1'b1;
        send(1'b0, 2'd2, 5'd0, 5'd6, 5'd5, 3'd0, 13'h1800, 1'b1, 32'h80532023);
        finish0 = 1'b0;
        in_valid = 1'b0;
        wait_done(1'b0);
        chk("t4_count", 32'(cnt0), 32'd1);

        // DEPTH=4 instance: six descriptors offered, only four accepted
        pulse_start(1'b1);
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 2'd0, 5'(i + 1), 5'd0, 5'd0, 3'd0, 13'(i),
                 1'b1, (32'(i) << 20) | (32'(i + 1) << 7) | 32'h13);
        end
        chk("t5_ready_dropped", 32'(rdy4), 32'd0);
        for (int i = 4; i < 6; i++) begin
            in_rd = 5'(i + 1);
            in_imm = 13'(i);
            @(negedge clk);
            chk("t5_ready_low", 32'(rdy4), 32'd0);
        end
        in_valid = 1'b0;
        wait_done(1'b1);
        chk("t5_count", 32'(cnt4), 32'd4);
        chk("t5_err", 32'(err4), 32'd0);

        // Reset one cycle after an acceptance drops the in-flight word
        pulse_start(1'b0);
        send(1'b0, 2'd0, 5'd7, 5'd7, 5'd0, 3'd0, 13'd9, 1'b0, 32'd0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6_rst_ready", 32'(rdy0), 32'd0);
        chk("t6_rst_wr_en", 32'(wen0), 32'd0);
        chk("t6_rst_wr_addr", 32'(waddr0), 32'd0);
        chk("t6_rst_wr_data", wdata0, 32'd0);
        chk("t6_rst_count", 32'(cnt0), 32'd0);
        chk("t6_rst_err", 32'(err0), 32'd0);
        chk("t6_rst_busy", 32'(busy0), 32'd0);
        chk("t6_rst_done", 32'(done0), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_idle_busy", 32'(busy0), 32'd0);
        chk("t6_idle_count", 32'(cnt0), 32'd0);

        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q4_drained", 32'(q4.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation time exceeded");
        $fatal(1);
    end

endmodule
